// File: rtl/life_scan_reader.sv
// Scan-chain readback controller for the 4x4 life array: rotates the chain 16 times and rebuilds a snapshot.
// Define LIFE_SCAN_CHECK_EN to add the post-scan CHECK state that flags a failed restore on `mismatch`.
module life_scan_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        run_req,
    output logic        run,
    output logic        scan,
    input  logic [15:0] alive,
    output logic        busy,
    output logic [15:0] snapshot,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic        mismatch
);

    typedef enum logic [1:0] {IDLE, SCAN, CHECK, HOLD} state_t;

    state_t      state_q;
    logic [3:0]  k_q;
    logic        scan_q;
    logic        busy_q;
    logic        snap_valid_q;
    logic [15:0] snapshot_q;
    logic [15:0] snapshot_d;
    logic [3:0]  p;
    logic [3:0]  snap_idx;

    // Step k sees the cell at col (p mod 4), row (p div 4) of the original image, with p = 15-k.
    assign p        = 4'd15 - k_q;
    assign snap_idx = {p[1:0], p[3:2]};

    always_comb begin
        // NOTE: default assignment first so the indexed update below cannot infer a latch.
        snapshot_d           = snapshot_q;
        snapshot_d[snap_idx] = alive[15];
    end

`ifdef LIFE_SCAN_CHECK_EN
    logic mismatch_q;
    assign mismatch = mismatch_q;
`else
    logic unused_alive_bits;
    assign unused_alive_bits = ^alive[14:0];
    assign mismatch          = 1'b0;
`endif

    // The array must not step while its cells are travelling round the chain.
    assign run        = run_req & ~busy_q;
    assign scan       = scan_q;
    assign busy       = busy_q;
    assign snapshot   = snapshot_q;
    assign snap_valid = snap_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= 4'd0;
            scan_q       <= 1'b0;
            busy_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            snapshot_q   <= 16'h0000;
`ifdef LIFE_SCAN_CHECK_EN
            mismatch_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every branch reads the pre-edge register values.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        k_q     <= 4'd0;
                        scan_q  <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef LIFE_SCAN_CHECK_EN
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    snapshot_q <= snapshot_d;
                    k_q        <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        scan_q <= 1'b0;
                        k_q    <= 4'd0;
`ifdef LIFE_SCAN_CHECK_EN
                        state_q <= CHECK;
`else
                        state_q      <= HOLD;
                        busy_q       <= 1'b0;
                        snap_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef LIFE_SCAN_CHECK_EN
                CHECK: begin
                    mismatch_q   <= (alive != snapshot_q);
                    state_q      <= HOLD;
                    busy_q       <= 1'b0;
                    snap_valid_q <= 1'b1;
                end
`endif
                HOLD: begin
                    if (snap_ready) begin
                        state_q      <= IDLE;
                        snap_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_scan_reader.sv
// Bench for life_scan_reader: behavioural 4x4 life array plus a snapshot scoreboard.
// Honours LIFE_SCAN_CHECK_EN for latency and mismatch expectations.
module tb_life_scan_reader;

`ifdef LIFE_SCAN_CHECK_EN
    localparam int   LAT     = 18;
    localparam logic MIS_INJ = 1'b1;
`else
    localparam int   LAT     = 17;
    localparam logic MIS_INJ = 1'b0;
`endif

    typedef struct {
        logic [15:0] snap;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        run_req;
    logic        run;
    logic        scan;
    logic [15:0] alive;
    logic        busy;
    logic [15:0] snapshot;
    logic        snap_valid;
    logic        snap_ready;
    logic        mismatch;

    logic        wr_en;
    logic [15:0] wr_val;
    logic [15:0] arr;

    exp_t sb_q[$];
    int   pass_cnt;
    int   chk_cnt;

    life_scan_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_req    (run_req),
        .run        (run),
        .scan       (scan),
        .alive      (alive),
        .busy       (busy),
        .snapshot   (snapshot),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .mismatch   (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order in which cells arrive at (3,3) as the chain rotates.
    function automatic logic [15:0] rotate(input logic [15:0] a);
        int chain [16] = '{15, 11, 7, 3, 14, 10, 6, 2, 13, 9, 5, 1, 12, 8, 4, 0};
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[chain[i]] = a[chain[(i + 1) % 16]];
        return r;
    endfunction

    function automatic logic [15:0] life_step(input logic [15:0] a);
        logic [15:0] r;
        int n;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                n = 0;
                for (int dc = -1; dc <= 1; dc++) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        if ((dc != 0 || dr != 0) && c + dc >= 0 && c + dc < 4 && rw + dr >= 0 && rw + dr < 4)
                            n += int'(a[(c + dc) * 4 + rw + dr]);
                    end
                end
                r[c * 4 + rw] = (n == 3) || (a[c * 4 + rw] && n == 2);
            end
        end
        return r;
    endfunction

    function automatic int idx_of(input int k);
        int pp;
        pp = 15 - k;
        return 4 * (pp % 4) + pp / 4;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)      arr <= 16'h0000;
        else if (wr_en) arr <= wr_val;
        else if (scan)  arr <= rotate(arr);
        else if (run)   arr <= life_step(arr);
    end
    assign alive = arr;

    task automatic load(input logic [15:0] v);
        wr_en  = 1'b1;
        wr_val = v;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic release_snap();
        snap_ready = 1'b1;
        @(negedge clk);
        snap_ready = 1'b0;
    endtask

    // Called at a negedge; pulses start and returns at the negedge where snap_valid is first seen.
    task automatic run_readback(input string name, input logic [15:0] exp_snap, input logic exp_mis,
                                input int inj_cyc, input logic [15:0] inj_val,
                                output int run_low, output logic [15:0] raw_order, output logic mis_c1);
        exp_t e;
        int   cyc;
        int   scan_cnt;
        int   busy_bad;
        sb_q.push_back('{snap: exp_snap, mis: exp_mis});
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        scan_cnt  = 0;
        busy_bad  = 0;
        run_low   = 0;
        raw_order = '0;
        mis_c1    = mismatch;
        while (!snap_valid && cyc < 64) begin
            if (scan) begin
                if (scan_cnt < 16) raw_order[15 - scan_cnt] = arr[15];
                scan_cnt++;
            end
            if (!busy) busy_bad++;
            if (!run)  run_low++;
            wr_en  = (cyc == inj_cyc);
            wr_val = inj_val;
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0;
        chk_cnt++;
        if (!snap_valid) $display("FAIL %s timeout: snap_valid not seen after %0d cycles", name, cyc);
        else pass_cnt++;
        chk_cnt++;
        if (cyc !== LAT) $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
        else pass_cnt++;
        chk_cnt++;
        if (scan_cnt !== 16 || busy_bad !== 0)
            $display("FAIL %s scan/busy: scan cycles %0d expected 16, busy-low cycles %0d expected 0", name, scan_cnt, busy_bad);
        else pass_cnt++;
        e = sb_q.pop_front();
        chk_cnt++;
        if (snapshot !== e.snap || mismatch !== e.mis)
            $display("FAIL %s result: snapshot %h mismatch %b expected %h %b", name, snapshot, mismatch, e.snap, e.mis);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({scan, busy, snap_valid, mismatch, run, snapshot} !== 21'h0)
            $display("FAIL reset_state: scan %b busy %b valid %b mis %b run %b snap %h expected all 0",
                     scan, busy, snap_valid, mismatch, run, snapshot);
        else pass_cnt++;
        run_req = 1'b1;
        #1;
        chk_cnt++;
        if (run !== 1'b1) $display("FAIL reset_run: got %b expected 1", run);
        else pass_cnt++;
        run_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_cell();
        int rl; logic [15:0] raw; logic m1;
        load(16'h0001);
        run_readback("single_cell", 16'h0001, 1'b0, -1, 16'h0, rl, raw, m1);
        chk_cnt++;
        if (arr !== 16'h0001) $display("FAIL single_cell_restore: alive %h expected 0001", arr);
        else pass_cnt++;
        release_snap();
    endtask

    task automatic test_pattern();
        int rl; logic [15:0] raw; logic m1; logic [15:0] rebuilt;
        load(16'hA5C3);
        run_readback("pattern", 16'hA5C3, 1'b0, -1, 16'h0, rl, raw, m1);
        chk_cnt++;
        if (raw !== 16'hA695) $display("FAIL capture_order: raw %h expected a695", raw);
        else pass_cnt++;
        rebuilt = '0;
        for (int k = 0; k < 16; k++) rebuilt[idx_of(k)] = raw[15 - k];
        chk_cnt++;
        if (snapshot !== rebuilt) $display("FAIL index_rule: snapshot %h expected %h", snapshot, rebuilt);
        else pass_cnt++;
        release_snap();
        chk_cnt++;
        if (arr !== 16'hA5C3) $display("FAIL pattern_restore: alive %h expected a5c3", arr);
        else pass_cnt++;
    endtask

    task automatic test_run_gating();
        int rl; logic [15:0] raw; logic m1;
        load(16'h0070);
        run_req = 1'b1;
        #1;
        chk_cnt++;
        if (run !== 1'b1) $display("FAIL run_cycle0: got %b expected 1", run);
        else pass_cnt++;
        run_readback("blinker", life_step(16'h0070), 1'b0, -1, 16'h0, rl, raw, m1);
        chk_cnt++;
        if (rl !== LAT - 1) $display("FAIL run_gated: run low for %0d cycles expected %0d", rl, LAT - 1);
        else pass_cnt++;
        chk_cnt++;
        if (run !== 1'b1) $display("FAIL run_hold: got %b expected 1", run);
        else pass_cnt++;
        run_req = 1'b0;
        release_snap();
    endtask

    task automatic test_handshake();
        int rl; logic [15:0] raw; logic m1; int unstable;
        load(16'h1234);
        run_readback("handshake", 16'h1234, 1'b0, -1, 16'h0, rl, raw, m1);
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (snapshot !== 16'h1234 || snap_valid !== 1'b1) unstable++;
        end
        chk_cnt++;
        if (unstable !== 0) $display("FAIL hold_stable: %0d unstable cycles expected 0", unstable);
        else pass_cnt++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({scan, busy, snap_valid} !== 3'b001)
            $display("FAIL start_in_hold: scan/busy/valid %b expected 001", {scan, busy, snap_valid});
        else pass_cnt++;
        release_snap();
        chk_cnt++;
        if (snap_valid !== 1'b0) $display("FAIL ready_release: snap_valid %b expected 0", snap_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int rl; logic [15:0] raw; logic m1;
        load(16'h8421);
        run_readback("b2b_first", 16'h8421, 1'b0, -1, 16'h0, rl, raw, m1);
        release_snap();
        run_readback("b2b_second", 16'h8421, 1'b0, -1, 16'h0, rl, raw, m1);
        release_snap();
    endtask

    task automatic test_reset_mid_scan();
        int rl; logic [15:0] raw; logic m1;
        load(16'hFFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({scan, busy, snap_valid} !== 3'b000 || snapshot !== 16'h0000 || arr !== 16'h0000)
            $display("FAIL reset_mid_scan: scan/busy/valid %b snap %h alive %h expected 000 0000 0000",
                     {scan, busy, snap_valid}, snapshot, arr);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_readback("after_reset", 16'h0000, 1'b0, -1, 16'h0, rl, raw, m1);
        release_snap();
    endtask

    task automatic test_mismatch();
        int rl; logic [15:0] raw; logic m1;
        run_readback("mismatch_set", 16'h0000, MIS_INJ, 16, 16'h0200, rl, raw, m1);
        release_snap();
        run_readback("mismatch_clear", 16'h0200, 1'b0, -1, 16'h0, rl, raw, m1);
        chk_cnt++;
        if (m1 !== 1'b0) $display("FAIL mismatch_clear_on_start: got %b expected 0", m1);
        else pass_cnt++;
        release_snap();
    endtask

    initial begin
        pass_cnt   = 0;
        chk_cnt    = 0;
        reset      = 1'b1;
        start      = 1'b0;
        run_req    = 1'b0;
        snap_ready = 1'b0;
        wr_en      = 1'b0;
        wr_val     = 16'h0000;
        test_reset();
        test_single_cell();
        test_pattern();
        test_run_gating();
        test_handshake();
        test_back_to_back();
        test_reset_mid_scan();
        test_mismatch();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
